// File: rtl/vga_tile_scheduler_if.sv
// RAM port and game-write handshake between the tile scheduler and the board.
// master: scheduler side; slave: RAM / game-logic side.
interface vga_tile_scheduler_if;
  logic [9:0] mem_addr;
  logic       mem_re;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       gw_valid;
  logic [9:0] gw_addr;
  logic [7:0] gw_data;
  logic       gw_ready;

  modport master (
    output mem_addr, mem_re, mem_we, mem_wdata, gw_ready,
    input  mem_rdata, gw_valid, gw_addr, gw_data
  );

  modport slave (
    input  mem_addr, mem_re, mem_we, mem_wdata, gw_ready,
    output mem_rdata, gw_valid, gw_addr, gw_data
  );
endinterface

// File: rtl/vga_tile_scheduler.sv
// Prefetches 20x20 tile codes from the shared board RAM ahead of each tile
// boundary; game-logic writes use the RAM only when no VGA fetch is pending.
module vga_tile_scheduler #(
  parameter int TILE_PX  = 20,
  parameter int COLS_T   = 32,
  parameter int ROWS_T   = 24,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int PREFETCH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] col,
  input  logic [9:0] row,
  vga_tile_scheduler_if.master bus,
  output logic       wr_err,
  output logic [7:0] state_out,
  output logic       state_vld
);

  localparam int TILE_COLS = H_ACTIVE / TILE_PX;

  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_CAPT} state_t;

  state_t     state, state_nx;
  logic [4:0] px_q, tcol_q, px, tcol;
  logic [4:0] cur_tr, rit, ntr, nrit;
  logic [9:0] fetch_addr, due_addr;
  logic [7:0] next_tile;
  logic       active, at_end, px_wrap, last_row, line_ok;
  logic       due_a, due_b, fetch_due, in_range, accept;

  // Counters read as zero on col==0 so they resync every line.
  assign px   = (col == '0) ? '0 : px_q;
  assign tcol = (col == '0) ? '0 : tcol_q;

  assign active   = col < 10'(H_ACTIVE);
  assign at_end   = col == 10'(H_ACTIVE);
  assign px_wrap  = active && (px == 5'(TILE_PX - 1));
  assign last_row = row == 10'(V_TOTAL - 1);
  assign line_ok  = last_row ||
                    (({1'b0, row} + 11'd1) < 11'(V_ACTIVE));

  always_comb begin
    ntr  = cur_tr;
    nrit = rit + 5'd1;
    if (last_row) begin
      ntr  = '0;
      nrit = '0;
    end else if (rit == 5'(TILE_PX - 1)) begin
      ntr  = cur_tr + 5'd1;
      nrit = '0;
    end
  end

  assign due_a = active && (px == 5'(PREFETCH)) &&
                 (tcol < 5'(COLS_T - 1));
  assign due_b = at_end && line_ok;
  assign fetch_due = due_a || due_b;
  assign due_addr  = due_a ? {cur_tr, tcol + 5'd1}
                           : {ntr, 5'd0};

  assign in_range = (bus.gw_addr[9:5] < 5'(ROWS_T)) &&
                    (32'(bus.gw_addr[4:0]) < TILE_COLS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      px_q   <= '0;
      tcol_q <= '0;
      cur_tr <= '0;
      rit    <= '0;
    end else begin
      if (active) begin
        px_q   <= px_wrap ? '0 : px + 5'd1;
        tcol_q <= px_wrap ? tcol + 5'd1 : tcol;
      end
      if (due_b) begin
        cur_tr <= ntr;
        rit    <= nrit;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      fetch_addr <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && fetch_due)
        fetch_addr <= due_addr;
    end
  end

  always_comb begin
    state_nx      = state;
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = fetch_addr;
    bus.mem_wdata = '0;
    bus.gw_ready  = 1'b0;
    accept        = 1'b0;
    unique case (state)
      IDLE: begin
        bus.gw_ready = ~fetch_due & reset;
        accept       = bus.gw_valid & bus.gw_ready;
        if (fetch_due) begin
          state_nx = RD_ISSUE;
        end else if (accept && in_range) begin
          bus.mem_we    = 1'b1;
          bus.mem_addr  = bus.gw_addr;
          bus.mem_wdata = bus.gw_data;
        end
      end
      RD_ISSUE: begin
        bus.mem_re = 1'b1;
        state_nx   = RD_CAPT;
      end
      RD_CAPT: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      next_tile <= '0;
      wr_err    <= 1'b0;
      state_out <= '0;
      state_vld <= 1'b0;
    end else begin
      if (state == RD_CAPT)
        next_tile <= bus.mem_rdata;
      if (accept && !in_range)
        wr_err <= 1'b1;
      if (at_end || row >= 10'(V_ACTIVE)) begin
        state_out <= '0;
        state_vld <= 1'b0;
      end else if (col == '0 || px_wrap) begin
        state_out <= next_tile;
        state_vld <= 1'b1;
      end
    end
  end

endmodule
